expr_vector_driver: RTL and testbench
=====================================

// Module: expr_vector_driver
// PURPOSE
//   Sequential stimulus/response harness for the 90-bit expression cores.
//   Generates pseudo-random packed operand vectors {a0..a5,b0..b5} (60 bits) over a
//   valid/ready handshake and receives each core's 90-bit packed result {y0..y17}.
//   Compresses the results into a 32-bit MISR signature. The signature is compared
//   across implementations in regression.
// PARAMETERS
//   STIM_W   60             operand bus width, {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, a0 at MSB
//   RESP_W   90             result bus width, {y0..y17}, y0 at MSB
//   SIG_W    32             MISR width
//   CNT_W    16             vector counter width
//   TIMEOUT  255            max WAIT cycles without resp_valid before error
//   MISR_POLY 32'h04C11DB7  MISR feedback polynomial
// PORTS
//   clk         in   1       clock, all logic rising-edge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       1-cycle pulse; begins a run (ignored while busy)
//   seed        in   32      LFSR seed, sampled on accepted start
//   num_vec     in   CNT_W   vectors per run, sampled on accepted start
//   stim        out  STIM_W  operand vector, registered
//   stim_valid  out  1       stim is valid
//   stim_ready  in   1       core/wrapper accepts stim
//   resp        in   RESP_W  packed result
//   resp_valid  in   1       resp is valid (1 cycle per vector)
//   busy        out  1       run in progress
//   done        out  1       run finished, held until next accepted start
//   err         out  1       timeout occurred in this run
//   signature   out  SIG_W   MISR state
//   vec_count   out  CNT_W   responses absorbed this run
// BEHAVIOUR
//   - Reset: all outputs 0, lfsr=0, state IDLE; asserting rst_n low mid-run aborts immediately.
//   - LFSR: 64-bit Galois, taps 64,63,61,60. On start: lfsr={~seed,seed}, never zero.
//     stim=lfsr[59:0]. Advances exactly once per stim handshake (stim_valid&stim_ready).
//   - Fold: f = {6'b0,resp[89:64]} ^ resp[63:32] ^ resp[31:0].
//     MISR step: sig <= {sig[30:0],1'b0} ^ (sig[31]?MISR_POLY:0) ^ f.
//   - FSM: IDLE, DRIVE, WAIT, DONE. busy=1 in DRIVE/WAIT; done=1 in DONE only.
//     IDLE/DONE + start: load seed/num_vec; clear sig, vec_count, err, tmo.
//       Next state is DONE if num_vec==0, else DRIVE.
//     DRIVE: stim_valid=1. stim stable while !stim_ready. On handshake -> WAIT.
//       stim_valid drops in the same edge.
//     WAIT: stim_valid=0, tmo counts up. On resp_valid: MISR step, vec_count++, tmo=0.
//       Then DONE if vec_count+1==num_vec, else DRIVE.
//       tmo==TIMEOUT with no resp_valid: err=1 -> DONE, signature frozen.
//   - resp_valid outside WAIT is ignored. start while busy is ignored.
//   - Latency: at most one outstanding vector; min 2 cycles per vector.
//   - vec_count saturates never (bounded by num_vec); all adds are CNT_W-bit unsigned.
// STRUCTURE
//   - Package expr_vec_pkg: STIM_W/RESP_W/SIG_W defaults, MISR_POLY, LFSR tap mask,
//     state enum {IDLE,DRIVE,WAIT,DONE}.
//   - Sub-module expr_misr: fold plus MISR register (clk, rst_n, clr, en, resp, sig).
//   - Top holds FSM, LFSR, counters.
// TESTING
//   1. rst_n low mid-WAIT -> all outputs 0 asynchronously, state IDLE.
//   2. start, num_vec=0 -> done=1 next cycle, signature=0, vec_count=0, stim_valid never 1.
//   3. seed=1, num_vec=1 -> first stim=60'hFFFFFFE00000001.
//      resp=90'h1 -> signature=32'h1, vec_count=1, done=1.
//   4. num_vec=2, resp=90'h1 each -> signature=32'h3.
//      resp=90'h1 then resp={26'h1,64'h0} -> signature=32'h3.
//   5. stim_ready low 5 cycles in DRIVE -> stim/stim_valid stable; lfsr advances once on accept.
//   6. No resp_valid in WAIT -> err=1, done=1 after 256 WAIT cycles.
//      Spurious resp_valid in DRIVE -> signature unchanged.

Source files
------------

// File: rtl/expr_vector_driver_pkg.sv
// rtl/expr_vector_driver_pkg.sv - shared widths, constants, state encoding and LFSR helper
//
// Purpose : common definitions for the expression-core vector driver.
// Contents: bus widths, MISR polynomial, LFSR tap mask, timeout limit,
//           FSM state enum, one-step Galois LFSR function.
package expr_vec_pkg;

    localparam int STIM_W = 60;
    localparam int RESP_W = 90;
    localparam int SIG_W  = 32;
    localparam int CNT_W  = 16;
    localparam int LFSR_W = 64;
    localparam int TMO_W  = 8;

    localparam logic [TMO_W-1:0]  TIMEOUT   = 8'd255;
    localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;

    // Taps 64,63,61,60 expressed as bit positions 63,62,60,59 of a right-shifting Galois register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One Galois step: shift right, fold the outgoing bit back into the tap positions.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] shifted;
        shifted = {1'b0, s[LFSR_W-1:1]};
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/expr_vector_driver_if.sv
// rtl/expr_vector_driver_if.sv - stimulus/response handshake bundle between driver and core
//
// Signals:
//   stim       operand vector {a0..a5,b0..b5}, a0 at MSB
//   stim_valid stim holds a vector not yet accepted
//   stim_ready core accepts stim
//   resp       packed result {y0..y17}, y0 at MSB
//   resp_valid resp is valid for one cycle per vector
// Modports: master = driver side, slave = core side.
interface expr_vector_driver_if;
    import expr_vec_pkg::*;

    logic [STIM_W-1:0] stim;
    logic              stim_valid;
    logic              stim_ready;
    logic [RESP_W-1:0] resp;
    logic              resp_valid;

    modport master (
        output stim,
        output stim_valid,
        input  stim_ready,
        input  resp,
        input  resp_valid
    );

    modport slave (
        input  stim,
        input  stim_valid,
        output stim_ready,
        output resp,
        output resp_valid
    );

endinterface

// File: rtl/expr_vector_driver_misr.sv
// rtl/expr_vector_driver_misr.sv - response fold and 32-bit MISR signature register
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clr    in  synchronous clear of the signature (start of run)
//   en     in  absorb resp this cycle
//   resp   in  RESP_W packed result
//   sig    out SIG_W signature state
module expr_misr
    import expr_vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    localparam int HI_W = RESP_W - 2 * SIG_W;

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_fold;
    logic [SIG_W-1:0] w_next;

    // The 90-bit result is folded to 32 bits; the 26-bit top slice is zero-extended.
    always_comb begin
        w_fold = {{(SIG_W-HI_W){1'b0}}, resp[RESP_W-1:2*SIG_W]}
               ^ resp[2*SIG_W-1:SIG_W]
               ^ resp[SIG_W-1:0];
        w_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
               ^ w_fold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/expr_vector_driver.sv
// rtl/expr_vector_driver.sv - LFSR stimulus generator and MISR response compactor for expression cores
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a run when not busy
//   seed       in   32-bit LFSR seed, sampled on accepted start
//   num_vec    in   vectors per run, sampled on accepted start
//   vif        master side of the stim/resp handshake
//   busy       out  run in progress (DRIVE or WAIT)
//   done       out  run finished, held until next accepted start
//   err        out  response timeout occurred in this run
//   signature  out  MISR state
//   vec_count  out  responses absorbed this run
module expr_vector_driver
    import expr_vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [CNT_W-1:0]     num_vec,
    expr_vector_driver_if.master vif,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [SIG_W-1:0]     signature,
    output logic [CNT_W-1:0]     vec_count
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_DRIVE = ST_DRIVE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]        r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [CNT_W-1:0]  r_num_vec;
    logic [CNT_W-1:0]  r_vec_count;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_err;

    logic              w_start_ok;
    logic              w_stim_hs;
    logic              w_resp_hit;
    logic [CNT_W-1:0]  w_vec_inc;
    logic [SIG_W-1:0]  w_sig;

    // A new run may only begin from a quiescent state; start during DRIVE/WAIT is dropped.
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_stim_hs  = (r_state == S_DRIVE) && vif.stim_ready;
    // Responses are only meaningful while a vector is outstanding.
    assign w_resp_hit = (r_state == S_WAIT) && vif.resp_valid;
    assign w_vec_inc  = r_vec_count + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= '0;
            r_num_vec   <= '0;
            r_vec_count <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        // {~seed,seed} can never be all zeros, so the LFSR cannot lock up.
                        r_lfsr      <= {~seed, seed};
                        r_num_vec   <= num_vec;
                        r_vec_count <= '0;
                        r_tmo       <= '0;
                        r_err       <= 1'b0;
                        r_state     <= (num_vec == '0) ? S_DONE : S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // LFSR holds while stalled so stim stays stable until accepted.
                    if (w_stim_hs) begin
                        r_lfsr  <= lfsr_next(r_lfsr);
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vif.resp_valid) begin
                        r_vec_count <= w_vec_inc;
                        r_tmo       <= '0;
                        r_state     <= (w_vec_inc == r_num_vec) ? S_DONE : S_DRIVE;
                    end else if (r_tmo == TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    expr_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_ok),
        .en    (w_resp_hit),
        .resp  (vif.resp),
        .sig   (w_sig)
    );

    assign vif.stim       = r_lfsr[STIM_W-1:0];
    assign vif.stim_valid = (r_state == S_DRIVE);

    assign busy      = (r_state == S_DRIVE) || (r_state == S_WAIT);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign signature = w_sig;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_expr_vector_driver.sv
// tb/tb_expr_vector_driver.sv - self-checking bench for expr_vector_driver
module tb_expr_vector_driver;
    import expr_vec_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       seed = '0;
    logic [15:0]       num_vec = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       signature;
    logic [15:0]       vec_count;

    expr_vector_driver_if bus();

    expr_vector_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .num_vec   (num_vec),
        .vif       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .signature (signature),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [59:0] exp_q[$];
    logic [31:0] m_sig;

    function automatic logic [63:0] m_lfsr_next(input logic [63:0] s);
        logic [63:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 64'hD800_0000_0000_0000;
        return t;
    endfunction

    function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [89:0] r);
        logic [31:0] f;
        f = {6'b0, r[89:64]} ^ r[63:32] ^ r[31:0];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    function automatic logic [89:0] rnd90();
        return 90'({$urandom, $urandom, $urandom});
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run(input logic [31:0] sd, input logic [15:0] n);
        logic [63:0] l;
        exp_q.delete();
        m_sig = '0;
        l = {~sd, sd};
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(l[59:0]);
            l = m_lfsr_next(l);
        end
        start = 1'b1;
        seed = sd;
        num_vec = n;
        tick();
        start = 1'b0;
    endtask

    task automatic do_vector(input logic [89:0] r, input int stall, input bit spurious, input bit give_resp);
        int w;
        bit stable;
        logic [59:0] s0;
        logic [59:0] e;
        w = 0;
        while (bus.stim_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (bus.stim_valid !== 1'b1) begin
            errors++;
            $display("FAIL stim_valid_wait: stim_valid=%b required 1", bus.stim_valid);
            return;
        end
        s0 = bus.stim;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (spurious && i == 0) begin
                bus.resp = rnd90() | 90'h1;
                bus.resp_valid = 1'b1;
            end
            tick();
            bus.resp_valid = 1'b0;
            if (bus.stim !== s0 || bus.stim_valid !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) begin
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL stall_stable: stim=%h valid=%b required stim=%h valid=1", bus.stim, bus.stim_valid, s0);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: stim=%h required no vector", bus.stim);
            return;
        end
        e = exp_q.pop_front();
        if (bus.stim !== e) begin
            errors++;
            $display("FAIL stim_value: stim=%h required %h", bus.stim, e);
        end
        bus.stim_ready = 1'b1;
        tick();
        bus.stim_ready = 1'b0;
        checks++;
        if (bus.stim_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: stim_valid=%b busy=%b required 0/1", bus.stim_valid, busy);
        end
        if (give_resp) begin
            bus.resp = r;
            bus.resp_valid = 1'b1;
            tick();
            bus.resp_valid = 1'b0;
            m_sig = m_misr(m_sig, r);
        end
    endtask

    task automatic finish_run(input logic [15:0] n, input logic exp_err);
        int w;
        w = 0;
        while (done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_done: done=%b busy=%b required 1/0", done, busy);
        end
        checks++;
        if (signature !== m_sig) begin
            errors++;
            $display("FAIL run_signature: signature=%h required %h", signature, m_sig);
        end
        checks++;
        if (vec_count !== n || err !== exp_err) begin
            errors++;
            $display("FAIL run_count_err: vec_count=%0d err=%b required %0d/%b", vec_count, err, n, exp_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || signature !== 32'h0 ||
            vec_count !== 16'h0 || bus.stim_valid !== 1'b0 || bus.stim !== 60'h0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b err=%b sig=%h cnt=%0d sv=%b stim=%h required all 0",
                     name, busy, done, err, signature, vec_count, bus.stim_valid, bus.stim);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_single();
        start_run(32'h1, 16'd1);
        checks++;
        if (bus.stim !== 60'hFFFFFFE00000001) begin
            errors++;
            $display("FAIL seed1_first_stim: stim=%h required 0FFFFFFE00000001", bus.stim);
        end
        do_vector(90'h1, 0, 1'b0, 1'b1);
        finish_run(16'd1, 1'b0);
        checks++;
        if (signature !== 32'h1) begin
            errors++;
            $display("FAIL single_signature: signature=%h required 00000001", signature);
        end
    endtask

    task automatic test_zero();
        bit seen;
        start_run(32'h1234, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || signature !== 32'h0 || vec_count !== 16'h0) begin
            errors++;
            $display("FAIL zero_run: done=%b busy=%b sig=%h cnt=%0d required 1/0/0/0", done, busy, signature, vec_count);
        end
        seen = (bus.stim_valid === 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.stim_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL zero_no_stim: stim_valid seen=1 required 0");
        end
    endtask

    task automatic test_fold();
        start_run(32'h7, 16'd2);
        do_vector(90'h1, 0, 1'b0, 1'b1);
        do_vector(90'h1, 0, 1'b0, 1'b1);
        finish_run(16'd2, 1'b0);
        checks++;
        if (signature !== 32'h3) begin
            errors++;
            $display("FAIL fold_low: signature=%h required 00000003", signature);
        end
        start_run(32'h9, 16'd2);
        do_vector(90'h1, 0, 1'b0, 1'b1);
        do_vector({26'h1, 64'h0}, 0, 1'b0, 1'b1);
        finish_run(16'd2, 1'b0);
        checks++;
        if (signature !== 32'h3) begin
            errors++;
            $display("FAIL fold_high: signature=%h required 00000003", signature);
        end
    endtask

    task automatic test_stall();
        start_run(32'hCAFE_F00D, 16'd3);
        do_vector(rnd90(), 5, 1'b1, 1'b1);
        // start while busy must be ignored
        start = 1'b1;
        seed = 32'hDEAD_BEEF;
        num_vec = 16'd1;
        tick();
        start = 1'b0;
        do_vector(rnd90(), 3, 1'b1, 1'b1);
        do_vector(rnd90(), 0, 1'b0, 1'b1);
        finish_run(16'd3, 1'b0);
    endtask

    task automatic test_timeout();
        int c;
        logic [31:0] frozen;
        start_run(32'h5, 16'd2);
        do_vector(rnd90(), 0, 1'b0, 1'b1);
        do_vector(90'h0, 0, 1'b0, 1'b0);
        c = 0;
        while (done !== 1'b1 && c < 400) begin
            tick();
            c++;
        end
        checks++;
        if (c != 256) begin
            errors++;
            $display("FAIL timeout_cycles: waited=%0d required 256", c);
        end
        finish_run(16'd1, 1'b1);
        frozen = m_sig;
        bus.resp = rnd90() | 90'h1;
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        tick();
        checks++;
        if (signature !== frozen || vec_count !== 16'd1) begin
            errors++;
            $display("FAIL resp_in_done: sig=%h cnt=%0d required %h/1", signature, vec_count, frozen);
        end
    endtask

    task automatic test_reset_mid_wait();
        start_run(32'h3, 16'd3);
        do_vector(rnd90(), 0, 1'b0, 1'b1);
        do_vector(90'h0, 0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_wait");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("idle_after_abort");
    endtask

    task automatic test_back_to_back();
        start_run($urandom, 16'd6);
        for (int i = 0; i < 6; i++) begin
            do_vector(rnd90(), 0, 1'b0, 1'b1);
        end
        finish_run(16'd6, 1'b0);
    endtask

    initial begin
        bus.stim_ready = 1'b0;
        bus.resp = '0;
        bus.resp_valid = 1'b0;
        test_reset();
        test_single();
        test_zero();
        test_fold();
        test_stall();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
